// File: rtl/hier_pkg.sv
// rtl/hier_pkg.sv - shared types, limits and index helper for the child sequencer
package hier_pkg;

    localparam int MAX_CHILDREN = 32;
    localparam int IDX_W        = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        WAIT     = 2'd2,
        FINISH   = 2'd3
    } hier_state_e;

    // Index of the lowest child that is enabled and not yet served; 0 if none.
    function automatic logic [IDX_W-1:0] lowest_set(
        input logic [MAX_CHILDREN-1:0] mask,
        input logic [MAX_CHILDREN-1:0] served
    );
        logic [MAX_CHILDREN-1:0] avail;
        avail      = mask & ~served;
        lowest_set = '0;
        for (int i = MAX_CHILDREN - 1; i >= 0; i--) begin
            if (avail[i]) begin
                lowest_set = IDX_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/hier_child_sequencer_if.sv
// rtl/hier_child_sequencer_if.sv - parent/children handshake bundle for the child sequencer
interface hier_child_sequencer_if #(
    parameter int NUM_CHILDREN = 5
);
    logic                    start_i;
    logic [NUM_CHILDREN-1:0] child_en_i;
    logic                    busy_o;
    logic                    done_o;
    logic                    err_o;
    logic [NUM_CHILDREN-1:0] child_start_o;
    logic [NUM_CHILDREN-1:0] child_done_i;

    modport master (
        output start_i, child_en_i, child_done_i,
        input  busy_o, done_o, err_o, child_start_o
    );

    modport slave (
        input  start_i, child_en_i, child_done_i,
        output busy_o, done_o, err_o, child_start_o
    );
endinterface

// File: rtl/hier_watchdog.sv
// rtl/hier_watchdog.sv - wait-phase watchdog counter
module hier_watchdog #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [W-1:0] count;

    // Restart on every entry to the wait phase, count each waiting cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    // Fires in the waiting cycle whose increment brings the counter to all-ones.
    assign expired = enable && ((count + W'(1)) == {W{1'b1}});
endmodule

// File: rtl/hier_child_sequencer.sv
// rtl/hier_child_sequencer.sv - start/done child sequencer; optional watchdog under HIER_TIMEOUT_EN
module hier_child_sequencer
    import hier_pkg::*;
#(
    parameter int NUM_CHILDREN = 5,
    parameter int PARALLEL     = 0,
    parameter int TIMEOUT_W    = 8
) (
    input logic                   clk,
    input logic                   rst,
    hier_child_sequencer_if.slave bus
);
    typedef logic [NUM_CHILDREN-1:0] vec_t;

    if (NUM_CHILDREN < 1 || NUM_CHILDREN > MAX_CHILDREN || TIMEOUT_W < 1) begin : g_param_check
        $error("hier_child_sequencer: NUM_CHILDREN must be 1..32 and TIMEOUT_W at least 1");
    end

    hier_state_e      state;
    vec_t             mask;
    vec_t             served;
    vec_t             done_seen;
    vec_t             child_start;
    logic [IDX_W-1:0] idx;
    logic             busy;
    logic             done;
    logic             err;

    logic             cur_hit;
    vec_t             done_now;
    logic             all_done;
    logic             more;
    logic [IDX_W-1:0] first_idx;
    logic [IDX_W-1:0] next_idx;
    logic             timeout;

    // Completion detection and next-child selection from the captured mask.
    always_comb begin
        cur_hit   = |(bus.child_done_i & (vec_t'(1) << idx));
        done_now  = bus.child_done_i & mask;
        all_done  = ((done_seen | done_now) == mask);
        more      = |(mask & ~served);
        first_idx = lowest_set(MAX_CHILDREN'(bus.child_en_i), '0);
        next_idx  = lowest_set(MAX_CHILDREN'(mask), MAX_CHILDREN'(served));
    end

`ifdef HIER_TIMEOUT_EN
    hier_watchdog #(
        .W(TIMEOUT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == DISPATCH),
        .enable (state == WAIT),
        .expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // Run control: capture, dispatch, wait for children, report; outputs registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            child_start <= '0;
            mask        <= '0;
            served      <= '0;
            done_seen   <= '0;
            idx         <= '0;
        end else begin
            child_start <= '0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        mask      <= bus.child_en_i;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        done_seen <= '0;
                        if (bus.child_en_i == '0) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else if (PARALLEL != 0) begin
                            child_start <= bus.child_en_i;
                            state       <= DISPATCH;
                        end else begin
                            idx         <= first_idx;
                            child_start <= vec_t'(1) << first_idx;
                            served      <= vec_t'(1) << first_idx;
                            state       <= DISPATCH;
                        end
                    end
                end
                DISPATCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (PARALLEL != 0) begin
                        if (all_done) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else if (timeout) begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= FINISH;
                        end else begin
                            done_seen <= done_seen | done_now;
                        end
                    end else begin
                        if (cur_hit) begin
                            if (more) begin
                                idx         <= next_idx;
                                child_start <= vec_t'(1) << next_idx;
                                served      <= served | (vec_t'(1) << next_idx);
                                state       <= DISPATCH;
                            end else begin
                                done  <= 1'b1;
                                state <= FINISH;
                            end
                        end else if (timeout) begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o        = busy;
    assign bus.done_o        = done;
    assign bus.err_o         = err;
    assign bus.child_start_o = child_start;
endmodule

// File: tb/tb_hier_child_sequencer.sv
// tb/tb_hier_child_sequencer.sv - timeline-model bench for sequential and parallel sequencers
module tb_hier_child_sequencer;
    localparam int N = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hier_child_sequencer_if #(.NUM_CHILDREN(5)) s_if ();
    hier_child_sequencer_if #(.NUM_CHILDREN(5)) p_if ();

    hier_child_sequencer #(.NUM_CHILDREN(5), .PARALLEL(0), .TIMEOUT_W(4)) u_seq (
        .clk(clk), .rst(rst), .bus(s_if)
    );
    hier_child_sequencer #(.NUM_CHILDREN(5), .PARALLEL(1), .TIMEOUT_W(4)) u_par (
        .clk(clk), .rst(rst), .bus(p_if)
    );

    // Whole-run timeline: index 0 = sequential instance, 1 = parallel instance.
    bit       drv_rst   [N];
    bit       drv_start [2][N];
    bit [4:0] drv_en    [2][N];
    bit [4:0] drv_cd    [2][N];
    bit [4:0] exp_cs    [2][N];
    bit       exp_busy  [2][N];
    bit       exp_done  [2][N];
    bit       exp_err   [2][N];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit checking = 1'b0;
    int last_cyc = 0;

    task automatic pin(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL pin_%s: model gives %0d, hand value %0d", name, got, want);
        end
    endtask

    // One accepted run starting with start_i high in cycle a; d = cycle of the done pulse.
    task automatic plan_run(input int p, input int a, input bit [4:0] m, input int lat[5], output int d);
        int s;
        int mx;
        drv_start[p][a] = 1'b1;
        drv_en[p][a]    = m;
        if (m == 5'd0) begin
            d = a + 1;
        end else if (p == 1) begin
            mx = 0;
            for (int i = 0; i < 5; i++) begin
                if (m[i]) begin
                    exp_cs[p][a+1][i]        = 1'b1;
                    drv_cd[p][a+1+lat[i]][i] = 1'b1;
                    if (lat[i] > mx) mx = lat[i];
                end
            end
            d = a + 1 + mx + 1;
        end else begin
            s = a + 1;
            for (int i = 0; i < 5; i++) begin
                if (m[i]) begin
                    exp_cs[p][s][i]        = 1'b1;
                    drv_cd[p][s+lat[i]][i] = 1'b1;
                    s = s + lat[i] + 1;
                end
            end
            d = s;
        end
        for (int c = a + 1; c <= d; c++) begin
            exp_busy[p][c]  = 1'b1;
            drv_start[p][c] = 1'($urandom_range(0, 1));
            drv_cd[p][c]    = drv_cd[p][c] | (5'($urandom) & ~m);
        end
        exp_done[p][d] = 1'b1;
    endtask

    task automatic rand_lat(output int lat[5]);
        for (int i = 0; i < 5; i++) lat[i] = int'($urandom_range(1, 8));
    endtask

    task automatic build();
        int a;
        int d;
        int d0;
        int d1;
        int r;
        int ar;
        int clr_end;
        int ends[2];
        int lat[5];
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < N; c++) drv_en[p][c] = 5'($urandom);
        drv_rst[0] = 1'b1;
        drv_rst[1] = 1'b1;
        for (int p = 0; p < 2; p++) begin
            a   = 3;
            lat = '{3, 3, 3, 3, 3};
            plan_run(p, a, 5'b11111, lat, d);
            if (p == 0) begin
                pin("seq_all_done", d - a, 21);
                pin("seq_all_child4_start", int'(exp_cs[0][a+17]), 16);
            end else begin
                pin("par_all_done", d - a, 5);
            end
            a   = d + 1;
            lat = '{2, 7, 3, 7, 4};
            plan_run(p, a, 5'b10101, lat, d);
            if (p == 0) begin
                pin("seq_10101_done", d - a, 13);
                pin("seq_10101_child2_start", int'(exp_cs[0][a+4]), 4);
            end
            a   = d + 2;
            lat = '{4, 6, 6, 6, 2};
            plan_run(p, a, 5'b11111, lat, d);
            if (p == 1) pin("par_mixed_done", d - a, 8);
            a   = d + 1;
            plan_run(p, a, 5'b00000, lat, d);
            pin("zero_mask_done", d - a, 1);
            for (int k = 0; k < 25; k++) begin
                a = d + 1 + int'($urandom_range(0, 3));
                rand_lat(lat);
                plan_run(p, a, 5'($urandom), lat, d);
            end
`ifdef HIER_TIMEOUT_EN
            a = d + 2;
            drv_start[p][a] = 1'b1;
            drv_en[p][a]    = 5'b00001;
            exp_cs[p][a+1]  = 5'b00001;
            d = a + 17;
            for (int c = a + 1; c <= d; c++) begin
                exp_busy[p][c]  = 1'b1;
                drv_start[p][c] = 1'($urandom_range(0, 1));
                drv_cd[p][c]    = 5'($urandom) & 5'b11110;
            end
            exp_done[p][d] = 1'b1;
            exp_err[p][d]  = 1'b1;
            drv_cd[p][d+3] = 5'b00001;
            a = d + 1;
            rand_lat(lat);
            plan_run(p, a, 5'b01011, lat, d);
`endif
            ends[p] = d;
        end
        ar  = ((ends[0] > ends[1]) ? ends[0] : ends[1]) + 2;
        lat = '{4, 4, 4, 4, 4};
        plan_run(0, ar, 5'b11111, lat, d0);
        lat = '{14, 14, 14, 14, 14};
        plan_run(1, ar, 5'b11111, lat, d1);
        r = ar + 8;
        drv_rst[r] = 1'b1;
        clr_end = ((d0 > d1) ? d0 : d1) + 2;
        for (int p = 0; p < 2; p++) begin
            for (int c = ar + 1; c <= r; c++) drv_start[p][c] = 1'b1;
            for (int c = r + 1; c <= clr_end; c++) begin
                exp_cs[p][c]    = '0;
                exp_busy[p][c]  = 1'b0;
                exp_done[p][c]  = 1'b0;
                exp_err[p][c]   = 1'b0;
                drv_start[p][c] = 1'b0;
                drv_cd[p][c]    = '0;
            end
        end
        for (int p = 0; p < 2; p++) begin
            rand_lat(lat);
            plan_run(p, clr_end + 1, 5'b11010, lat, d);
            ends[p] = d;
        end
        last_cyc = ((ends[0] > ends[1]) ? ends[0] : ends[1]) + 3;
    endtask

    task automatic cmp(input int p, input int c, input logic [4:0] cs, input logic b,
                       input logic dn, input logic e);
        logic [7:0] got;
        logic [7:0] want;
        got  = {cs, b, dn, e};
        want = {exp_cs[p][c], exp_busy[p][c], exp_done[p][c], exp_err[p][c]};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s_outputs cycle %0d: got start=%b busy=%b done=%b err=%b, want start=%b busy=%b done=%b err=%b",
                     (p == 0) ? "seq" : "par", c, cs, b, dn, e,
                     want[7:3], want[2], want[1], want[0]);
        end
    endtask

    // Compare both instances against the timeline in the middle of every cycle.
    always @(negedge clk) begin
        if (checking) begin
            cmp(0, cyc, s_if.child_start_o, s_if.busy_o, s_if.done_o, s_if.err_o);
            cmp(1, cyc, p_if.child_start_o, p_if.busy_o, p_if.done_o, p_if.err_o);
        end
    end

    initial begin
        build();
        for (int c = 0; c <= last_cyc; c++) begin
            rst               = drv_rst[c];
            s_if.start_i      = drv_start[0][c];
            s_if.child_en_i   = drv_en[0][c];
            s_if.child_done_i = drv_cd[0][c];
            p_if.start_i      = drv_start[1][c];
            p_if.child_en_i   = drv_en[1][c];
            p_if.child_done_i = drv_cd[1][c];
            cyc               = c;
            checking          = (c >= 1);
            @(posedge clk);
            #1;
        end
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
